// File: rtl/pixel_aer_arbiter.sv
// Address-event arbiter for a ROWS x COLS pixel array: round-robin row groups,
// lowest-column-first within a group, one address event per ready handshake.
module pixel_aer_arbiter #(
  parameter  int ROWS  = 4,
  parameter  int COLS  = 4,
  parameter  int CNT_W = 16,
  localparam int XW    = ($clog2(ROWS) > 1) ? $clog2(ROWS) : 1,
  localparam int YW    = ($clog2(COLS) > 1) ? $clog2(COLS) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      enable_i,
  input  logic [ROWS-1:0][COLS-1:0] req_i,
  input  logic                      ready_i,
  output logic [ROWS-1:0][COLS-1:0] gnt_o,
  output logic [XW-1:0]             x_add_o,
  output logic [YW-1:0]             y_add_o,
  output logic                      valid_o,
  output logic                      req_o,
  output logic                      active_o,
  output logic                      grp_release_o,
  output logic [CNT_W-1:0]          evt_cnt_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROW_ARB = 2'd1,
    COL_ARB = 2'd2,
    SEND    = 2'd3
  } state_t;

  state_t          state;
  logic [XW-1:0]   rr_row;
  logic [COLS-1:0] col_mask;

  logic            row_found;
  logic [XW-1:0]   row_sel;
  logic            col_found;
  logic [YW-1:0]   col_sel;

  // Rows strictly above rr_row take priority, then the search wraps to row 0.
  always_comb begin
    row_found = 1'b0;
    row_sel   = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (!row_found && (XW'(r) > rr_row) && (|req_i[r])) begin
        row_found = 1'b1;
        row_sel   = XW'(r);
      end
    end
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (!row_found && (XW'(r) <= rr_row) && (|req_i[r])) begin
        row_found = 1'b1;
        row_sel   = XW'(r);
      end
    end
  end

  always_comb begin
    col_found = 1'b0;
    col_sel   = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (!col_found && col_mask[c]) begin
        col_found = 1'b1;
        col_sel   = YW'(c);
      end
    end
  end

  assign req_o = |req_i;

  // Combinational so the pulse lands in the COL_ARB cycle that finds the group
  // empty, and is suppressed in the same cycle when enable_i drops.
  assign grp_release_o = (state == COL_ARB) && enable_i && !col_found;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state     <= IDLE;
      rr_row    <= XW'(ROWS - 1);
      col_mask  <= '0;
      x_add_o   <= '0;
      y_add_o   <= '0;
      valid_o   <= 1'b0;
      gnt_o     <= '0;
      active_o  <= 1'b0;
      evt_cnt_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable_i && req_o) begin
            state    <= ROW_ARB;
            active_o <= 1'b1;
          end
        end

        ROW_ARB: begin
          if (!enable_i || !row_found) begin
            state    <= IDLE;
            active_o <= 1'b0;
            col_mask <= '0;
          end else begin
            x_add_o  <= row_sel;
            col_mask <= req_i[row_sel];
            rr_row   <= row_sel;
            state    <= COL_ARB;
          end
        end

        COL_ARB: begin
          if (!enable_i) begin
            state    <= IDLE;
            active_o <= 1'b0;
            col_mask <= '0;
          end else if (col_found) begin
            y_add_o                 <= col_sel;
            valid_o                 <= 1'b1;
            gnt_o                   <= '0;
            gnt_o[x_add_o][col_sel] <= 1'b1;
            state                   <= SEND;
          end else begin
            state <= ROW_ARB;
          end
        end

        SEND: begin
          if (ready_i) begin
            valid_o            <= 1'b0;
            gnt_o              <= '0;
            col_mask[y_add_o]  <= 1'b0;
            evt_cnt_o          <= evt_cnt_o + CNT_W'(1);
            if (enable_i) begin
              state <= COL_ARB;
            end else begin
              state    <= IDLE;
              active_o <= 1'b0;
              col_mask <= '0;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_aer_arbiter.sv
// Bench for pixel_aer_arbiter: directed per-cycle vector table, hand-written
// fairness/reset sequences, then random traffic against a schedule-based model.
module tb_pixel_aer_arbiter;
  localparam int ROWS = 4;
  localparam int COLS = 4;

  logic clk_i = 1'b0;
  logic reset_i, enable_i, ready_i;
  logic [ROWS-1:0][COLS-1:0] req_i, gnt_o, gnt_w;
  logic [1:0]  x_add_o, y_add_o, x_w, y_w;
  logic        valid_o, req_o, active_o, grp_release_o;
  logic        valid_w, req_w, active_w, rel_w;
  logic [15:0] evt_cnt_o;
  logic [2:0]  cnt_w;

  pixel_aer_arbiter #(.ROWS(ROWS), .COLS(COLS), .CNT_W(16)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i), .req_i(req_i),
    .ready_i(ready_i), .gnt_o(gnt_o), .x_add_o(x_add_o), .y_add_o(y_add_o),
    .valid_o(valid_o), .req_o(req_o), .active_o(active_o),
    .grp_release_o(grp_release_o), .evt_cnt_o(evt_cnt_o)
  );

  // Narrow-counter twin sharing every input, so counter wrap is exercised often.
  pixel_aer_arbiter #(.ROWS(ROWS), .COLS(COLS), .CNT_W(3)) dut_w (
    .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i), .req_i(req_i),
    .ready_i(ready_i), .gnt_o(gnt_w), .x_add_o(x_w), .y_add_o(y_w),
    .valid_o(valid_w), .req_o(req_w), .active_o(active_w),
    .grp_release_o(rel_w), .evt_cnt_o(cnt_w)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pix(input int x, input int y);
    return 16'(1) << (x * COLS + y);
  endfunction

  task automatic check_out(input string tag, input logic ev, input int ex, input int ey,
                           input logic ea, input logic er, input int ec);
    logic [31:0] eg;
    eg = ev ? 32'(pix(ex, ey)) : 32'd0;
    chk({tag, ".valid"}, 32'(valid_o), 32'(ev));
    chk({tag, ".gnt"}, 32'(gnt_o), eg);
    chk({tag, ".active"}, 32'(active_o), 32'(ea));
    chk({tag, ".release"}, 32'(grp_release_o), 32'(er));
    chk({tag, ".cnt"}, 32'(evt_cnt_o), 32'(ec) & 32'hFFFF);
    chk({tag, ".valid_w"}, 32'(valid_w), 32'(ev));
    chk({tag, ".gnt_w"}, 32'(gnt_w), eg);
    chk({tag, ".active_w"}, 32'(active_w), 32'(ea));
    chk({tag, ".release_w"}, 32'(rel_w), 32'(er));
    chk({tag, ".cnt_w"}, 32'(cnt_w), 32'(ec) & 32'h7);
    if (ev) begin
      chk({tag, ".x"}, 32'(x_add_o), 32'(ex));
      chk({tag, ".y"}, 32'(y_add_o), 32'(ey));
      chk({tag, ".x_w"}, 32'(x_w), 32'(ex));
      chk({tag, ".y_w"}, 32'(y_w), 32'(ey));
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_i = 1'b0; req_i = '0; ready_i = 1'b0; enable_i = 1'b1;
    @(negedge clk_i);
    check_out("reset", 1'b0, 0, 0, 1'b0, 1'b0, 0);
    chk("reset.x", 32'(x_add_o), 32'd0);
    chk("reset.y", 32'(y_add_o), 32'd0);
    reset_i = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk_i); #1;
      if (valid_o) ok = 1'b1;
    end
    chk({tag, ".valid_within_bound"}, 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic [15:0] req;
    logic        rdy;
    logic        en;
    logic        v;
    int          x;
    int          y;
    logic        act;
    logic        rel;
    int          cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [15:0] rq, input logic rdy, input logic en,
                              input logic v, input int x, input int y,
                              input logic act, input logic rel, input int cnt);
    vec_t e;
    e.req = rq; e.rdy = rdy; e.en = en; e.v = v; e.x = x; e.y = y;
    e.act = act; e.rel = rel; e.cnt = cnt;
    tbl.push_back(e);
  endfunction

  // Random-phase model: event schedule expressed as absolute cycle numbers.
  logic [15:0] pend;
  logic        m_idle, m_send, e_valid, rdy;
  int          snap_at, v_from, rel_at, m_rr, m_cnt, gx, gy, found;
  int          grp[$];
  int          served[$];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: no end of test, expected completion before 5 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_i = 1'b0; enable_i = 1'b1; ready_i = 1'b0; req_i = '0;

    // Single event, then row burst.
    add(pix(2,1), 1, 1, 0, 0, 0, 1, 0, 0);
    add(pix(2,1), 1, 1, 0, 0, 0, 1, 0, 0);
    add(pix(2,1), 1, 1, 1, 2, 1, 1, 0, 0);
    add(16'h0,    1, 1, 0, 0, 0, 1, 1, 1);
    add(16'h0,    1, 1, 0, 0, 0, 1, 0, 1);
    add(16'h0,    1, 1, 0, 0, 0, 0, 0, 1);
    add(pix(1,0) | pix(1,2) | pix(1,3), 1, 1, 0, 0, 0, 1, 0, 1);
    add(pix(1,0) | pix(1,2) | pix(1,3), 1, 1, 0, 0, 0, 1, 0, 1);
    add(pix(1,0) | pix(1,2) | pix(1,3), 1, 1, 1, 1, 0, 1, 0, 1);
    add(pix(1,2) | pix(1,3),            1, 1, 0, 0, 0, 1, 0, 2);
    add(pix(1,2) | pix(1,3),            1, 1, 1, 1, 2, 1, 0, 2);
    add(pix(1,3),                       1, 1, 0, 0, 0, 1, 0, 3);
    add(pix(1,3),                       1, 1, 1, 1, 3, 1, 0, 3);
    add(16'h0, 1, 1, 0, 0, 0, 1, 1, 4);
    add(16'h0, 1, 1, 0, 0, 0, 1, 0, 4);
    add(16'h0, 1, 1, 0, 0, 0, 0, 0, 4);
    // Backpressure: five SEND cycles with ready low.
    add(pix(3,2), 0, 1, 0, 0, 0, 1, 0, 4);
    add(pix(3,2), 0, 1, 0, 0, 0, 1, 0, 4);
    add(pix(3,2), 0, 1, 1, 3, 2, 1, 0, 4);
    for (int i = 0; i < 5; i++) add(pix(3,2), 0, 1, 1, 3, 2, 1, 0, 4);
    add(16'h0, 1, 1, 0, 0, 0, 1, 1, 5);
    add(16'h0, 1, 1, 0, 0, 0, 1, 0, 5);
    add(16'h0, 1, 1, 0, 0, 0, 0, 0, 5);
    // Enable dropped during SEND.
    add(pix(0,1), 0, 1, 0, 0, 0, 1, 0, 5);
    add(pix(0,1), 0, 1, 0, 0, 0, 1, 0, 5);
    add(pix(0,1), 0, 1, 1, 0, 1, 1, 0, 5);
    add(pix(0,1), 0, 0, 1, 0, 1, 1, 0, 5);
    add(pix(0,1), 0, 0, 1, 0, 1, 1, 0, 5);
    add(16'h0,    1, 0, 0, 0, 0, 0, 0, 6);
    add(16'h0,    0, 0, 0, 0, 0, 0, 0, 6);
    // Enable dropped during ROW_ARB.
    add(pix(2,0), 0, 1, 0, 0, 0, 1, 0, 6);
    add(pix(2,0), 0, 0, 0, 0, 0, 0, 0, 6);
    add(pix(2,0), 0, 0, 0, 0, 0, 0, 0, 6);
    add(pix(2,0), 0, 1, 0, 0, 0, 1, 0, 6);
    add(pix(2,0), 0, 1, 0, 0, 0, 1, 0, 6);
    add(pix(2,0), 0, 1, 1, 2, 0, 1, 0, 6);
    add(16'h0,    1, 1, 0, 0, 0, 1, 1, 7);
    add(16'h0,    1, 1, 0, 0, 0, 1, 0, 7);
    add(16'h0,    1, 1, 0, 0, 0, 0, 0, 7);
    // Enable dropped during COL_ARB.
    add(pix(1,3), 0, 1, 0, 0, 0, 1, 0, 7);
    add(pix(1,3), 0, 1, 0, 0, 0, 1, 0, 7);
    add(pix(1,3), 0, 0, 0, 0, 0, 0, 0, 7);
    add(pix(1,3), 0, 1, 0, 0, 0, 1, 0, 7);
    add(pix(1,3), 0, 1, 0, 0, 0, 1, 0, 7);
    add(pix(1,3), 0, 1, 1, 1, 3, 1, 0, 7);
    add(16'h0,    1, 1, 0, 0, 0, 1, 1, 8);
    add(16'h0,    1, 1, 0, 0, 0, 1, 0, 8);
    add(16'h0,    1, 1, 0, 0, 0, 0, 0, 8);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk_i);
      req_i = tbl[i].req; ready_i = tbl[i].rdy; enable_i = tbl[i].en;
      #1;
      chk($sformatf("vec%0d.req_o", i), 32'(req_o), 32'(tbl[i].req != 16'h0));
      chk($sformatf("vec%0d.req_w", i), 32'(req_w), 32'(tbl[i].req != 16'h0));
      @(posedge clk_i); #1;
      check_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].x, tbl[i].y,
                tbl[i].act, tbl[i].rel, tbl[i].cnt);
    end

    // Fairness: rows 0 and 3 request continuously; last group served was row 1.
    @(negedge clk_i);
    req_i = pix(0,0) | pix(3,3); ready_i = 1'b1; enable_i = 1'b1;
    for (int i = 0; i < 80 && served.size() < 8; i++) begin
      @(posedge clk_i); #1;
      if (valid_o) served.push_back(int'(x_add_o));
    end
    req_i = '0;
    chk("fair.events", 32'(served.size()), 32'd8);
    for (int k = 0; k < served.size(); k++)
      chk($sformatf("fair.row%0d", k), 32'(served[k]), (k % 2 == 0) ? 32'd3 : 32'd0);
    repeat (6) @(negedge clk_i);
    check_out("fair.end", 1'b0, 0, 0, 1'b0, 1'b0, 16);

    // Reset in the middle of SEND abandons the event; row search restarts at 0.
    req_i = pix(2,2) | pix(0,3); ready_i = 1'b0;
    wait_valid("midrst.pre");
    chk("midrst.pre.x", 32'(x_add_o), 32'd2);
    #2 reset_i = 1'b0;
    #1;
    check_out("midrst.async", 1'b0, 0, 0, 1'b0, 1'b0, 0);
    chk("midrst.x", 32'(x_add_o), 32'd0);
    chk("midrst.y", 32'(y_add_o), 32'd0);
    @(negedge clk_i);
    reset_i = 1'b1;
    wait_valid("midrst.post");
    check_out("midrst.post", 1'b1, 0, 3, 1'b1, 1'b0, 0);

    // Random traffic against the schedule model.
    do_reset();
    pend = '0; m_idle = 1'b1; m_send = 1'b0; snap_at = -1; v_from = 0;
    rel_at = -1; m_rr = ROWS - 1; m_cnt = 0; gx = 0; gy = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_i);
      e_valid = m_send && (c >= v_from);
      check_out("rnd", e_valid, gx, gy, !m_idle, c == rel_at, m_cnt);
      if ($urandom_range(0, 2) == 0) pend[$urandom_range(0, 15)] = 1'b1;
      rdy = ($urandom_range(0, 3) != 0);
      if (m_idle) begin
        if (pend != 16'h0) begin
          m_idle  = 1'b0;
          snap_at = c + 1;
        end
      end else if (c == snap_at) begin
        found = -1;
        for (int k = 1; k <= ROWS; k++) begin
          int r;
          r = (m_rr + k) % ROWS;
          if (found < 0 && pend[r*COLS +: COLS] != '0) found = r;
        end
        if (found < 0) begin
          m_idle = 1'b1;
        end else begin
          m_rr = found;
          grp.delete();
          for (int col = 0; col < COLS; col++)
            if (pend[found*COLS + col]) grp.push_back(col);
          gx = found; gy = grp[0]; m_send = 1'b1; v_from = c + 2;
        end
      end else if (e_valid && rdy) begin
        m_cnt = m_cnt + 1;
        pend[gx*COLS + gy] = 1'b0;
        void'(grp.pop_front());
        if (grp.size() > 0) begin
          gy = grp[0]; v_from = c + 2;
        end else begin
          m_send = 1'b0; rel_at = c + 1; snap_at = c + 2;
        end
      end
      req_i = pend; ready_i = rdy;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
